mux4x1_dataflow: RTL and testbench
==================================

// Module: mux4x1_dataflow
// PURPOSE
//   4-to-1 data selector with a registered output: picks one of four equal-width
//   inputs from a 2-bit select (s1,s0) and registers the result on clk.
//   Leaf datapath block used wherever a timing-clean, synchronously reset
//   4-way select is needed ahead of downstream registered logic.
// PARAMETERS
//   WIDTH      1    bit width of each data input and of y (legal: >=1)
//   RST_VAL    0    value loaded into y (and y_par) on reset, WIDTH bits
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst    in   1      synchronous, active-high reset
//   en     in   1      capture enable; 1 = load selected input into y
//   a      in   WIDTH  data input 0 (selected when s1,s0 = 0,0)
//   b      in   WIDTH  data input 1 (selected when s1,s0 = 0,1)
//   c      in   WIDTH  data input 2 (selected when s1,s0 = 1,0)
//   d      in   WIDTH  data input 3 (selected when s1,s0 = 1,1)
//   s0     in   1      select LSB
//   s1     in   1      select MSB
//   y      out  WIDTH  registered selected data
//   y_par  out  1      even parity of y (only when MUX4X1_PARITY_EN defined)
// BEHAVIOUR
//   - Interface: one clock (clk); rst is synchronous and active-high.
//   - sel = {s1,s0}: 00->a, 01->b, 10->c, 11->d. No other encodings exist.
//   - Selection is pure combinational (continuous-assign style); only y is state.
//   - Rising clk edge, priority order:
//       rst=1        -> y <= RST_VAL (en, sel, data ignored)
//       rst=0, en=1  -> y <= selected input
//       rst=0, en=0  -> y holds
//   - Latency: exactly 1 clk from data/select sampled to y; no bubbles, 1 result/cycle.
//   - Select and data changing in the same cycle: y reflects the values present at
//     the sampling edge; no glitch is visible on y (registered).
//   - Reset mid-operation: next edge forces RST_VAL regardless of prior y.
//   - Releasing rst with en=1: first post-reset edge loads selected input.
//   - X/Z on select: not defined for synthesis; sim y may go X, no checks required.
//   - No arithmetic; widths identical on all data paths, no truncation/extension.
//   - Before the first clk edge after power-up y is undefined; a reset is required.
// CONFIGURATION
//   - MUX4X1_PARITY_EN defined: port y_par present; y_par registered alongside y,
//     equals ^(value loaded into y) (even parity: y_par=1 when y has odd 1s);
//     reset value ^RST_VAL; holds when en=0.
//   - MUX4X1_PARITY_EN undefined: y_par port and its logic absent; all other
//     behaviour identical.
// TESTING
//   1 rst=1 two edges, any inputs -> y=0 (RST_VAL); release rst.
//   2 WIDTH=1, en=1, a=0 b=0 c=1 d=1, s1s0=01 -> after 1 edge y=0;
//     then a=1 b=1 c=0 d=1 same sel -> y=1; then a=0 b=0 c=1 d=1 -> y=0.
//   3 Sweep sel 00,01,10,11 with a=0 b=1 c=0 d=1 -> y sequence 0,1,0,1,
//     each one edge after sel applied.
//   4 en=0 while sel/data toggle for 5 cycles -> y holds last loaded value.
//   5 rst=1 asserted with en=1 and selected input=1 -> y=0 on that edge;
//     rst low next cycle -> y=1 one edge later.
//   6 WIDTH=8, MUX4X1_PARITY_EN: a=8'h00 b=8'h07 c=8'hFF d=8'h81, sel=01 -> y=8'h07
//     y_par=1; sel=11 -> y=8'h81 y_par=0; also rebuild without macro, same y.

Source files
------------

// File: rtl/mux4x1_dataflow.sv
// mux4x1_dataflow: 4:1 selector with a registered, synchronously reset output.
// Optional registered even parity on y_par when MUX4X1_PARITY_EN is defined.
module mux4x1_dataflow #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
`ifdef MUX4X1_PARITY_EN
  output logic             y_par,
`endif
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] y_d, y_q;
  assign y_d = s1 ? (s0 ? d : c) : (s0 ? b : a);
  always_ff @(posedge clk)
    if (rst) y_q <= RST_VAL;
    else if (en) y_q <= y_d;
  assign y = y_q;
`ifdef MUX4X1_PARITY_EN
  logic par_q;
  always_ff @(posedge clk)
    if (rst) par_q <= ^RST_VAL;
    else if (en) par_q <= ^y_d;
  assign y_par = par_q;
`endif
endmodule

// File: tb/tb_mux4x1_dataflow.sv
// tb_mux4x1_dataflow: scoreboard bench; driver pushes model results, monitor pops and compares.
module tb_mux4x1_dataflow;
  localparam int W = 8;
  logic clk = 0, rst = 1, en = 0, s0 = 0, s1 = 0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, y;
  logic y_par;
  typedef struct {logic [W-1:0] y; logic p;} exp_t;
  exp_t q[$];
  int vectors = 0, errors = 0;
  logic [W-1:0] model_y;
  bit model_valid = 0;

  always #5 clk = ~clk;

  mux4x1_dataflow #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
`ifdef MUX4X1_PARITY_EN
    .y_par(y_par),
`endif
    .y(y)
  );
`ifndef MUX4X1_PARITY_EN
  assign y_par = ^y;
`endif

  task automatic drive(input bit r, input bit e, input logic [W-1:0] ia, ib, ic, id, input int sel);
    logic [W-1:0] ins [4];
    exp_t x;
    @(negedge clk);
    rst = r; en = e; a = ia; b = ib; c = ic; d = id; s1 = sel[1]; s0 = sel[0];
    ins = '{ia, ib, ic, id};
    if (r) begin model_y = '0; model_valid = 1; end
    else if (e) begin model_y = ins[sel]; model_valid = 1; end
    if (model_valid) begin
      x.y = model_y;
      x.p = ^model_y;
      q.push_back(x);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (y !== x.y) begin
          errors++;
          $display("FAIL y: got %h want %h at %0t", y, x.y, $time);
        end
        if (y_par !== x.p) begin
          errors++;
          $display("FAIL y_par: got %b want %b at %0t", y_par, x.p, $time);
        end
      end
    end
  end

  initial begin : stim
    drive(1, 1, $urandom, $urandom, $urandom, $urandom, $urandom_range(3));
    drive(1, 0, $urandom, $urandom, $urandom, $urandom, $urandom_range(3));
    drive(0, 1, 8'h00, 8'h00, 8'h01, 8'h01, 1);
    drive(0, 1, 8'h01, 8'h01, 8'h00, 8'h01, 1);
    drive(0, 1, 8'h00, 8'h00, 8'h01, 8'h01, 1);
    for (int s = 0; s < 4; s++) drive(0, 1, 8'h00, 8'h01, 8'h00, 8'h01, s);
    for (int i = 0; i < 5; i++) drive(0, 0, $urandom, $urandom, $urandom, $urandom, $urandom_range(3));
    drive(0, 1, 8'h00, 8'hff, 8'h00, 8'h00, 1);
    drive(1, 1, 8'h00, 8'h01, 8'h00, 8'h00, 1);
    drive(0, 1, 8'h00, 8'h01, 8'h00, 8'h00, 1);
    drive(0, 1, 8'h00, 8'h07, 8'hff, 8'h81, 1);
    drive(0, 1, 8'h00, 8'h07, 8'hff, 8'h81, 3);
    drive(0, 1, 8'h00, 8'h07, 8'hff, 8'h81, 2);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(15) == 0, $urandom_range(3) != 0,
            $urandom, $urandom, $urandom, $urandom, $urandom_range(3));
    @(negedge clk);
    en = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
